// File: rtl/merge_if.sv
// Handshake/data bundle between the kernel compute array (master side)
// and the merge write-back serializer (slave side).
interface merge_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int KERNEL_LENGTH = 3
);
  logic                                    wen;
  logic [KERNEL_LENGTH-1:0][DATA_WIDTH-1:0] din;
  logic                                    ren;
  logic [DATA_WIDTH-1:0]                   dout;
  logic                                    valid;
  logic                                    last;
  logic                                    full_flag;
  logic                                    empty_flag;

  modport master (
    output wen, din, ren,
    input  dout, valid, last, full_flag, empty_flag
  );

  modport slave (
    input  wen, din, ren,
    output dout, valid, last, full_flag, empty_flag
  );
endinterface

// File: rtl/merge.sv
// merge: buffers one frame of BURST_LENGTH words on each of KERNEL_LENGTH
// parallel lanes, then serializes it lane-major onto a single stream for
// DMA write-back. Define MERGE_CHECKER_EN to expose internal pointers and
// RAM contents as debug ports.
module merge #(
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_LENGTH  = 32,
  parameter int KERNEL_LENGTH = 3
) (
  input  logic clk,
  input  logic rst,
  merge_if.slave bus
`ifdef MERGE_CHECKER_EN
  ,
  output logic [$clog2(KERNEL_LENGTH)-1:0]                   lane_i_checker,
  output logic [$clog2(BURST_LENGTH)-1:0]                    beat_i_checker,
  output logic [$clog2(BURST_LENGTH)-1:0]                    wptr_i_checker,
  output logic [KERNEL_LENGTH-1:0][BURST_LENGTH-1:0][DATA_WIDTH-1:0] mem_checker
`endif
);

  localparam int PW = (BURST_LENGTH  > 1) ? $clog2(BURST_LENGTH)  : 1;
  localparam int LW = (KERNEL_LENGTH > 1) ? $clog2(KERNEL_LENGTH) : 1;
  localparam logic [PW-1:0] LAST_BEAT = PW'(BURST_LENGTH - 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(KERNEL_LENGTH - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t                state;
  logic [PW-1:0]         wptr;
  logic [LW-1:0]         lane;
  logic [PW-1:0]         beat;
  logic [DATA_WIDTH-1:0] dout_r;
  logic                  valid_r;
  logic                  last_r;
  logic [DATA_WIDTH-1:0] mem [KERNEL_LENGTH][BURST_LENGTH];

  // Lane RAMs: all lanes written together at the shared pointer while filling.
  always_ff @(posedge clk) begin
    if (rst && state == FILL && bus.wen) begin
      for (int unsigned k = 0; k < KERNEL_LENGTH; k++) begin
        mem[k][wptr] <= bus.din[k];
      end
    end
  end

  // Frame FSM: fill pointer, drain counters and registered read outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= FILL;
      wptr    <= '0;
      lane    <= '0;
      beat    <= '0;
      dout_r  <= '0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          valid_r <= 1'b0;
          last_r  <= 1'b0;
          if (bus.wen) begin
            if (wptr == LAST_BEAT) begin
              wptr  <= '0;
              state <= DRAIN;
            end else begin
              wptr <= wptr + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bus.ren) begin
            dout_r  <= mem[lane][beat];
            valid_r <= 1'b1;
            last_r  <= (lane == LAST_LANE) && (beat == LAST_BEAT);
            if (beat == LAST_BEAT) begin
              beat <= '0;
              if (lane == LAST_LANE) begin
                lane  <= '0;
                state <= FILL;
              end else begin
                lane <= lane + 1'b1;
              end
            end else begin
              beat <= beat + 1'b1;
            end
          end else begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.dout       = dout_r;
  assign bus.valid      = valid_r;
  assign bus.last       = last_r;
  assign bus.full_flag  = (state == DRAIN);
  assign bus.empty_flag = (state == FILL) && (wptr == '0);

`ifdef MERGE_CHECKER_EN
  assign lane_i_checker = lane;
  assign beat_i_checker = beat;
  assign wptr_i_checker = wptr;

  // Flatten the lane RAMs onto the debug port.
  always_comb begin
    mem_checker = '0;
    for (int unsigned k = 0; k < KERNEL_LENGTH; k++) begin
      for (int unsigned b = 0; b < BURST_LENGTH; b++) begin
        mem_checker[k][b] = mem[k][b];
      end
    end
  end
`endif

endmodule

// File: tb/tb_merge.sv
// Testbench for merge: randomized and directed stimulus, frame-level
// reference model, scoreboard queue popped by an independent monitor.
module tb_merge;
  localparam int DW = 32;
  localparam int B  = 32;
  localparam int K  = 3;

  typedef logic [K-1:0][DW-1:0] din_t;
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  merge_if #(.DATA_WIDTH(DW), .KERNEL_LENGTH(K)) bus ();

`ifdef MERGE_CHECKER_EN
  logic [$clog2(K)-1:0]        lane_chk;
  logic [$clog2(B)-1:0]        beat_chk;
  logic [$clog2(B)-1:0]        wptr_chk;
  logic [K-1:0][B-1:0][DW-1:0] mem_chk;
`endif

  merge #(.DATA_WIDTH(DW), .BURST_LENGTH(B), .KERNEL_LENGTH(K)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MERGE_CHECKER_EN
    ,
    .lane_i_checker(lane_chk),
    .beat_i_checker(beat_chk),
    .wptr_i_checker(wptr_chk),
    .mem_checker(mem_chk)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a frame is a KxB array; filled in order, drained as a
  // flat index r = lane*B + beat.
  logic [DW-1:0] mbuf [K][B];
  int            mcount    = 0;
  int            mread     = 0;
  bit            mdraining = 1'b0;
  logic [DW-1:0] exp_dout  = '0;
  exp_t          sb[$];
  bit            started   = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model update on every rising edge from the inputs presented there.
  always @(posedge clk) begin
    started = 1'b1;
    if (!rst) begin
      mcount    = 0;
      mread     = 0;
      mdraining = 1'b0;
      exp_dout  = '0;
    end else if (!mdraining) begin
      if (bus.wen) begin
        for (int k = 0; k < K; k++) mbuf[k][mcount] = bus.din[k];
        mcount++;
        if (mcount == B) begin
          mdraining = 1'b1;
          mread     = 0;
        end
      end
    end else if (bus.ren) begin
      exp_t e;
      e.data   = mbuf[mread / B][mread % B];
      e.last   = (mread == K*B - 1);
      exp_dout = e.data;
      sb.push_back(e);
      mread++;
      if (mread == K*B) begin
        mdraining = 1'b0;
        mcount    = 0;
      end
    end
  end

  // Monitor: compare outputs and flags away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("full_flag",  {31'b0, bus.full_flag},  {31'b0, mdraining});
      chk("empty_flag", {31'b0, bus.empty_flag}, {31'b0, (!mdraining && mcount == 0)});
      chk("dout_hold",  bus.dout, exp_dout);
      if (bus.valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {31'b0, bus.valid}, '0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("dout", bus.dout, e.data);
          chk("last", {31'b0, bus.last}, {31'b0, e.last});
        end
      end else begin
        chk("last_without_valid", {31'b0, bus.last}, '0);
      end
      if (sb.size() != 0) begin
        chk("missing_valid", {31'b0, bus.valid}, 32'd1);
        sb.delete();
      end
    end
  end

  task automatic step(input logic r, input logic w, input logic rd, input din_t d);
    rst     = r;
    bus.wen = w;
    bus.ren = rd;
    bus.din = d;
    @(posedge clk);
    #1;
  endtask

  function automatic din_t mk(input int base, input int i);
    din_t d;
    for (int k = 0; k < K; k++) d[k] = DW'(k*100 + base + i);
    return d;
  endfunction

  function automatic din_t same(input int v);
    din_t d;
    for (int k = 0; k < K; k++) d[k] = DW'(v);
    return d;
  endfunction

  function automatic din_t rnd();
    din_t d;
    for (int k = 0; k < K; k++) d[k] = $urandom;
    return d;
  endfunction

  initial begin
    rst = 1'b0; bus.wen = 1'b1; bus.ren = 1'b1; bus.din = same(5);
    // Reset held with both strobes asserted.
    step(0, 1, 1, same(5));
    step(0, 1, 1, same(5));
    // Fill, then an ignored extra write, then continuous drain.
    for (int i = 0; i < B; i++) step(1, 1, 0, mk(1, i));
    step(1, 1, 0, same(999));
    for (int i = 0; i < K*B; i++) step(1, 0, 1, same(0));
    step(1, 0, 0, same(0));
    // Gapped drain.
    for (int i = 0; i < B; i++) step(1, 1, 0, mk(1, i));
    for (int i = 0; i < 2*K*B; i++) step(1, 0, (i % 2 == 0), same(0));
    step(1, 0, 0, same(0));
    // Cross-state requests: ren during fill, wen during drain.
    for (int i = 0; i < B; i++) step(1, 1, (i < 10) || (i == B-1), mk(1, i));
    for (int i = 0; i < K*B; i++) step(1, 1, 1, same(777));
    // wen right after the final read is accepted as the first new write.
    for (int i = 0; i < B; i++) step(1, 1, 0, mk(7, i));
    // Reset mid-drain, then a fresh frame.
    for (int i = 0; i < 40; i++) step(1, 0, 1, same(0));
    step(0, 0, 0, same(0));
    for (int i = 0; i < B; i++) step(1, 1, 0, mk(50, i));
    for (int i = 0; i < K*B; i++) step(1, 0, 1, same(0));
    step(1, 0, 0, same(0));
    // Randomized traffic with occasional reset.
    for (int i = 0; i < 1200; i++) begin
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0), rnd());
    end
    step(1, 0, 0, same(0));
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/merge.md
Name: merge

Overview:
- Write-back counterpart of the input line-buffer splitter.
- Takes KERNEL_LENGTH parallel result lanes, one word per lane per write, and buffers one frame of BURST_LENGTH words per lane.
- Serializes the frame into a single DATA_WIDTH stream for DMA write-back, in lane-major order: lane 0 words 0..B-1, then lane 1, and so on.
- Sits between the kernel compute array and the DMA write channel.

Parameters:
- DATA_WIDTH, 32, width of one data word.
- BURST_LENGTH, 32, words per lane per frame; also the per-lane buffer depth.
- KERNEL_LENGTH, 3, number of parallel input lanes.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- wen  in  1  write strobe; pushes din into all lanes at once.
- din  in  [KERNEL_LENGTH-1:0][DATA_WIDTH-1:0]  one word per lane; lane k is din[k].
- ren  in  1  read request for one serialized word.
- dout  out  DATA_WIDTH  serialized output word, registered.
- valid  out  1  dout holds a newly read word this cycle.
- last  out  1  qualifies the final word of a frame; only meaningful with valid.
- full_flag  out  1  frame complete or draining; writes are ignored while high.
- empty_flag  out  1  no words buffered.

Behaviour:
- Reset: rst==0 sampled at a rising clk edge.
  - state=FILL, wptr=0, lane=0, beat=0.
  - dout=0, valid=0, last=0, full_flag=0, empty_flag=1.
  - Buffer RAM contents are not reset.
  - Reset during any state abandons the current frame immediately.
- Storage: KERNEL_LENGTH arrays of BURST_LENGTH x DATA_WIDTH.
  - One shared write pointer wptr, $clog2(BURST_LENGTH) bits.
  - Read side uses counters lane (0..K-1) and beat (0..B-1).
- FSM has two states, FILL and DRAIN.
- FILL:
  - wen=1: mem[k][wptr] <= din[k] for every k; wptr++.
  - A write with wptr==B-1 sets wptr to 0 and moves to DRAIN on the same edge.
  - ren is ignored; valid and last stay 0.
- DRAIN:
  - wen is ignored; no RAM write and no pointer change.
  - ren=1 at an edge: dout <= mem[lane][beat], valid<=1, beat++.
  - At beat==B-1: beat<=0 and lane++.
  - At lane==K-1 and beat==B-1: last<=1, lane<=0, state<=FILL.
  - ren=0: valid<=0, last<=0, dout holds its last value.
- Latency: the word appears on dout with valid=1 on the cycle after the edge that accepted ren. Continuous ren gives 1 word/cycle, K*B cycles per frame, no bubbles.
- Flags, decoded combinationally from registered state:
  - full_flag = (state==DRAIN).
  - empty_flag = (state==FILL && wptr==0).
  - Both change in the cycle after the transition edge.
- Boundary cases:
  - wen and ren in the same cycle are legal. Only the operation matching the current state takes effect.
  - The final FILL write plus ren on the same edge: ren is dropped, and the first read is accepted at the next edge.
  - The last read of a frame plus wen on the same edge: wen is dropped, because state is still DRAIN.
  - wen in the first FILL cycle after a drain is accepted.
- All counters wrap exactly at B-1 and K-1; no out-of-range addressing.

Optional Feature:
- Macro: MERGE_CHECKER_EN.
- When defined, extra debug outputs are added:
  - lane_i_checker [$clog2(KERNEL_LENGTH)-1:0]
  - beat_i_checker [$clog2(BURST_LENGTH)-1:0]
  - wptr_i_checker [$clog2(BURST_LENGTH)-1:0]
  - mem_checker [KERNEL_LENGTH-1:0][BURST_LENGTH-1:0][DATA_WIDTH-1:0]
- These are direct copies of the internal registers and RAM, with no added latency.
- When undefined, these ports and their logic do not exist. Functional behaviour is identical either way.

Test Plan:
- Reset: hold rst=0 for 2 cycles with wen=ren=1 -> valid=0, last=0, dout=0, full_flag=0, empty_flag=1; no RAM pointer moves.
- Fill frame: 32 writes with din[k]=k*100+i+1 (i=0..31) -> empty_flag=0 after the first write; full_flag=1 after the 32nd. A 33rd write of 999 is ignored; first drained word is 1.
- Continuous drain: ren=1 for 96 cycles -> dout sequence 1..32, 101..132, 201..232, valid=1 each cycle starting one cycle after the first ren. last=1 only alongside 232. Then full_flag=0, empty_flag=1.
- Gapped drain: ren toggles 1/0 -> same 96-word sequence. valid pulses only after accepted reads; dout holds during gaps; last with 232.
- Cross-state requests: ren=1 while 10 words are written in FILL -> no valid. wen=1 with din=777 throughout DRAIN -> no 777 appears, sequence uncorrupted.
- Reset mid-drain: rst=0 after 40 reads -> empty_flag=1, valid=0. A new frame with din[k]=k*100+50+i drains starting at 50, with last at 281.
